// File: rtl/result_writeback_pkg.sv
// Shared defaults and FSM encoding for the result path (also used by systolic_array).
package result_writeback_pkg;

    localparam int ARRAY_SIZE_DEF = 4;
    localparam int ACC_WIDTH_DEF  = 32;
    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } wb_state_t;

endpackage

// File: rtl/requant_lane.sv
// One accumulator lane: round-half-up, arithmetic shift, optional ReLU, saturate.
module requant_lane #(
    parameter int ACC_WIDTH  = 32,
    parameter int DATA_WIDTH = 8
) (
    input  logic [ACC_WIDTH-1:0]  acc,
    input  logic [4:0]            shift,
    input  logic                  relu,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  sat
);

    // One extra bit so the rounding add can never overflow.
    localparam int EW = ACC_WIDTH + 1;
    localparam logic signed [EW-1:0] Q_MAX = EW'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [EW-1:0] Q_MIN = -EW'(2 ** (DATA_WIDTH - 1));

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] rnd;
    logic signed [EW-1:0] sum;
    logic signed [EW-1:0] shifted;
    logic signed [EW-1:0] clipped;

    always_comb begin
        ext = signed'({acc[ACC_WIDTH-1], acc});
        rnd = '0;
        if (shift != 5'd0) begin
            rnd = EW'(1) << (shift - 5'd1);
        end
        sum     = ext + rnd;
        shifted = sum >>> shift;
        clipped = (relu && shifted[EW-1]) ? '0 : shifted;
        q   = clipped[DATA_WIDTH-1:0];
        sat = 1'b0;
        if (clipped > Q_MAX) begin
            q   = Q_MAX[DATA_WIDTH-1:0];
            sat = 1'b1;
        end else if (clipped < Q_MIN) begin
            q   = Q_MIN[DATA_WIDTH-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/result_writeback.sv
// Requantizes accumulator rows and streams them to memory through a small FIFO.
module result_writeback
    import result_writeback_pkg::*;
#(
    parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [15:0]                      cfg_rows,
    input  logic [ADDR_WIDTH-1:0]            cfg_base_addr,
    input  logic [4:0]                       cfg_shift,
    input  logic                             cfg_relu,
    input  logic                             in_valid,
    input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]  in_data,
    output logic                             in_ready,
    output logic                             mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] mem_wdata,
    input  logic                             mem_ready,
    output logic                             busy,
    output logic                             done,
    output logic [15:0]                      sat_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ROW_W = ARRAY_SIZE * DATA_WIDTH;
    localparam int SUM_W = $clog2(ARRAY_SIZE + 1);

    wb_state_t state_reg, state_next;
    logic [15:0]           rows_reg;
    logic [4:0]            shift_reg;
    logic                  relu_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [15:0]           accepted_reg;
    logic [15:0]           sat_count_reg;
    logic                  pipe_valid_reg;
    logic [ROW_W-1:0]      pipe_data_reg;
    logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [ROW_W-1:0]      fifo_mem [FIFO_DEPTH];

    logic [ROW_W-1:0]      row_q;
    logic [ARRAY_SIZE-1:0] lane_sat;
    logic [SUM_W-1:0]      sat_lanes;
    logic [16:0]           sat_sum;
    logic [15:0]           sat_next;
    logic [CNT_W-1:0]      occupancy;
    logic                  accept, push, pop, start_job;

    genvar gi;
    generate
        for (gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
            requant_lane #(
                .ACC_WIDTH (ACC_WIDTH),
                .DATA_WIDTH(DATA_WIDTH)
            ) u_lane (
                .acc  (in_data[gi*ACC_WIDTH +: ACC_WIDTH]),
                .shift(shift_reg),
                .relu (relu_reg),
                .q    (row_q[gi*DATA_WIDTH +: DATA_WIDTH]),
                .sat  (lane_sat[gi])
            );
        end
    endgenerate

    // Rows still in the requant stage count against FIFO space.
    assign occupancy = count_reg + CNT_W'(pipe_valid_reg);
    assign in_ready  = (state_reg == ST_RUN) && (accepted_reg < rows_reg)
                       && (occupancy < CNT_W'(FIFO_DEPTH));
    assign accept    = in_valid && in_ready;
    assign push      = pipe_valid_reg;
    assign mem_we    = (count_reg != '0);
    assign pop       = mem_we && mem_ready;
    assign mem_addr  = mem_we ? addr_reg : '0;
    assign mem_wdata = mem_we ? fifo_mem[rd_ptr_reg] : '0;
    assign busy      = (state_reg != ST_IDLE);
    assign done      = (state_reg == ST_FIN);
    assign sat_count = sat_count_reg;

    always_comb begin
        sat_lanes = '0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            sat_lanes = sat_lanes + SUM_W'(lane_sat[i]);
        end
        sat_sum  = {1'b0, sat_count_reg} + 17'(sat_lanes);
        sat_next = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end

    always_comb begin
        state_next = state_reg;
        start_job  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    start_job  = 1'b1;
                    state_next = (cfg_rows == 16'd0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && (accepted_reg + 16'd1 == rows_reg)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Everything has been accepted; the last row leaves with this pop.
                if (pop && (count_reg == CNT_W'(1)) && !pipe_valid_reg) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            rows_reg       <= '0;
            shift_reg      <= '0;
            relu_reg       <= 1'b0;
            addr_reg       <= '0;
            accepted_reg   <= '0;
            sat_count_reg  <= '0;
            pipe_valid_reg <= 1'b0;
            pipe_data_reg  <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            pipe_valid_reg <= accept;
            if (accept) begin
                pipe_data_reg <= row_q;
                accepted_reg  <= accepted_reg + 16'd1;
                sat_count_reg <= sat_next;
            end
            if (start_job) begin
                rows_reg      <= cfg_rows;
                shift_reg     <= cfg_shift;
                relu_reg      <= cfg_relu;
                addr_reg      <= cfg_base_addr;
                accepted_reg  <= '0;
                sat_count_reg <= '0;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                addr_reg   <= addr_reg + ADDR_WIDTH'(1);
            end
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Row storage carries no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= pipe_data_reg;
        end
    end

endmodule
